// File: rtl/dma_priority_arbiter.sv
// DMA priority arbiter: resolves channel requests for the 4-channel DMA
// controller and runs the hold handshake with the CPU:
//   request -> HRQ -> HLDA -> DACK -> release.
//
// Handshake semantics: HRQ is the "valid" side and HLDA the "ready" side.
// Once HRQ rises, it stays high until one of three things happens: the
// latched channel's request is withdrawn before HLDA is seen, the service
// completes (transferDone), or the CPU withdraws HLDA during a grant (abort).
// A grant exists only in the cycle after HLDA is sampled high while HRQ is
// high. A new grant always needs a fresh HLDA low/high cycle.
//
// dbg_state and dbg_last_granted expose the FSM state and the rotation
// pointer so that external checkers can observe them.
module dma_priority_arbiter #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [NUM_CH-1:0] DREQ,
  input  logic [NUM_CH-1:0] requestReg,
  input  logic [NUM_CH-1:0] maskReg,
  input  logic              priorityType,
  input  logic              HLDA,
  input  logic              transferDone,
  output logic              HRQ,
  output logic [NUM_CH-1:0] DACK,
  output logic [CH_W-1:0]   activeChannel,
  output logic              grantValid,
  output logic              abortPulse,
  output logic [1:0]        dbg_state,
  output logic [CH_W-1:0]   dbg_last_granted
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    GRANT   = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [NUM_CH-1:0] ONE_HOT_BASE = {{(NUM_CH-1){1'b0}}, 1'b1};
  localparam logic [CH_W-1:0]   LAST_CH      = CH_W'(NUM_CH - 1);

  state_t              state;
  logic [CH_W-1:0]     last_granted;
  logic [NUM_CH-1:0]   eff_req;
  logic [CH_W-1:0]     fixed_winner;
  logic [CH_W-1:0]     rot_winner;
  logic [CH_W-1:0]     winner;
  logic                any_req;
  logic                active_req;

  // Effective request: hardware or software request, unless masked.
  always_comb begin
    eff_req    = (DREQ | requestReg) & ~maskReg;
    any_req    = |eff_req;
    active_req = eff_req[activeChannel];
  end

  // Fixed priority: the lowest-numbered requesting channel wins.
  // The loop runs from the highest index down, so the lowest index is
  // written last and therefore wins.
  always_comb begin
    fixed_winner = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (eff_req[i]) fixed_winner = CH_W'(i);
    end
  end

  // Rotating priority: the search starts just after the last serviced channel
  // and wraps around. The loop runs from the largest offset down, so the
  // channel closest to the pointer is written last and therefore wins.
  always_comb begin
    int idx;
    rot_winner = '0;
    idx        = 0;
    for (int off = NUM_CH; off >= 1; off--) begin
      idx = (int'(last_granted) + off) % NUM_CH;
      if (eff_req[idx]) rot_winner = CH_W'(idx);
    end
  end

  // Select the arbitration mode. priorityType only matters while in IDLE,
  // because winner is consumed only there.
  always_comb begin
    winner = priorityType ? rot_winner : fixed_winner;
  end

  // Hold-handshake FSM with registered outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state         <= IDLE;
      HRQ           <= 1'b0;
      DACK          <= '0;
      activeChannel <= '0;
      grantValid    <= 1'b0;
      abortPulse    <= 1'b0;
      last_granted  <= LAST_CH;
    end else begin
      abortPulse <= 1'b0;
      case (state)
        IDLE: begin
          DACK       <= '0;
          grantValid <= 1'b0;
          if (any_req) begin
            activeChannel <= winner;
            HRQ           <= 1'b1;
            state         <= REQ;
          end else begin
            HRQ <= 1'b0;
          end
        end
        REQ: begin
          // A request withdrawn before HLDA arrives cancels the hold.
          if (!active_req) begin
            HRQ   <= 1'b0;
            state <= IDLE;
          end else if (HLDA) begin
            HRQ        <= 1'b1;
            DACK       <= ONE_HOT_BASE << activeChannel;
            grantValid <= 1'b1;
            state      <= GRANT;
          end else begin
            HRQ <= 1'b1;
          end
        end
        GRANT: begin
          // Completion wins over an HLDA drop seen in the same cycle.
          if (transferDone) begin
            HRQ          <= 1'b0;
            DACK         <= '0;
            grantValid   <= 1'b0;
            last_granted <= activeChannel;
            state        <= RELEASE;
          end else if (!HLDA) begin
            HRQ        <= 1'b0;
            DACK       <= '0;
            grantValid <= 1'b0;
            abortPulse <= 1'b1;
            state      <= IDLE;
          end
        end
        RELEASE: begin
          // Wait for the CPU to take the bus back before arbitrating again.
          HRQ        <= 1'b0;
          DACK       <= '0;
          grantValid <= 1'b0;
          if (!HLDA) state <= IDLE;
        end
        default: begin
          HRQ        <= 1'b0;
          DACK       <= '0;
          grantValid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign dbg_state        = state;
  assign dbg_last_granted = last_granted;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed bench for dma_priority_arbiter. The expected grant channels are
// queued as each scenario is set up and popped as each grant appears.
module tb_dma_priority_arbiter;

  logic       CLK;
  logic       RESET_N;
  logic [3:0] DREQ;
  logic [3:0] requestReg;
  logic [3:0] maskReg;
  logic       priorityType;
  logic       HLDA;
  logic       transferDone;
  logic       HRQ;
  logic [3:0] DACK;
  logic [1:0] activeChannel;
  logic       grantValid;
  logic       abortPulse;
  logic [1:0] dbg_state;
  logic [1:0] dbg_last_granted;

  int errors;
  int checks;
  logic [1:0] exp_q[$];

  dma_priority_arbiter #(.NUM_CH(4), .CH_W(2)) dut (
    .CLK              (CLK),
    .RESET_N          (RESET_N),
    .DREQ             (DREQ),
    .requestReg       (requestReg),
    .maskReg          (maskReg),
    .priorityType     (priorityType),
    .HLDA             (HLDA),
    .transferDone     (transferDone),
    .HRQ              (HRQ),
    .DACK             (DACK),
    .activeChannel    (activeChannel),
    .grantValid       (grantValid),
    .abortPulse       (abortPulse),
    .dbg_state        (dbg_state),
    .dbg_last_granted (dbg_last_granted)
  );

  // Clock and reset.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; outputs are sampled and inputs driven at the negedge.
  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RESET_N      = 1'b0;
    DREQ         = '0;
    requestReg   = '0;
    maskReg      = '0;
    priorityType = 1'b0;
    HLDA         = 1'b0;
    transferDone = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
  endtask

  task automatic wait_hrq(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (HRQ === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_hrq_seen"}, {31'd0, seen}, 32'd1);
  endtask

  // Pop the expected channel and compare it with the grant now on the pins.
  task automatic score_grant(input string tag);
    logic [1:0] exp_ch;
    logic [3:0] exp_dack;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_nonempty"}, 32'd0, 32'd1);
    end else begin
      exp_ch   = exp_q.pop_front();
      exp_dack = 4'b0001 << exp_ch;
      check({tag, "_dack"}, {28'd0, DACK}, {28'd0, exp_dack});
      check({tag, "_active"}, {30'd0, activeChannel}, {30'd0, exp_ch});
    end
    check({tag, "_gv"}, {31'd0, grantValid}, 32'd1);
    check({tag, "_hrq"}, {31'd0, HRQ}, 32'd1);
  endtask

  // One full service: HRQ, HLDA two cycles later, grant, transferDone, release.
  task automatic serve(input string tag, input bit drop_req);
    wait_hrq(tag);
    tick();
    tick();
    HLDA = 1'b1;
    tick();
    score_grant(tag);
    tick();
    check({tag, "_gv_hold"}, {31'd0, grantValid}, 32'd1);
    tick();
    transferDone = 1'b1;
    tick();
    transferDone = 1'b0;
    check({tag, "_rel_hrq"}, {31'd0, HRQ}, 32'd0);
    check({tag, "_rel_dack"}, {28'd0, DACK}, 32'd0);
    check({tag, "_rel_gv"}, {31'd0, grantValid}, 32'd0);
    check({tag, "_rel_abort"}, {31'd0, abortPulse}, 32'd0);
    if (drop_req) begin
      DREQ       = '0;
      requestReg = '0;
    end
    HLDA = 1'b0;
    tick();
  endtask

  initial begin
    bit hrq_seen;
    errors = 0;
    checks = 0;
    do_reset();

    // Reset state.
    check("rst_hrq", {31'd0, HRQ}, 32'd0);
    check("rst_dack", {28'd0, DACK}, 32'd0);
    check("rst_active", {30'd0, activeChannel}, 32'd0);
    check("rst_gv", {31'd0, grantValid}, 32'd0);
    check("rst_abort", {31'd0, abortPulse}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    check("rst_last", {30'd0, dbg_last_granted}, 32'd3);

    // 1: fixed priority, DREQ=0110 -> ch1.
    exp_q.push_back(2'd1);
    DREQ = 4'b0110;
    serve("t1", 1'b1);

    // 2: fixed priority, all requesting -> ch0 every time.
    for (int i = 0; i < 4; i++) exp_q.push_back(2'd0);
    DREQ = 4'b1111;
    serve("t2a", 1'b0);
    serve("t2b", 1'b0);
    serve("t2c", 1'b0);
    serve("t2d", 1'b1);

    // 3: rotating priority from reset -> 0,1,2,3,0.
    do_reset();
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    priorityType = 1'b1;
    DREQ = 4'b1111;
    serve("t3a", 1'b0);
    serve("t3b", 1'b0);
    serve("t3c", 1'b0);
    serve("t3d", 1'b0);
    serve("t3e", 1'b1);

    // 4: masked channel never requests; software request on ch2 does.
    do_reset();
    maskReg = 4'b0001;
    DREQ    = 4'b0001;
    hrq_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (HRQ !== 1'b0) hrq_seen = 1'b1;
    end
    check("t4_masked_hrq", {31'd0, hrq_seen}, 32'd0);
    requestReg = 4'b0100;
    tick();
    check("t4_sw_hrq", {31'd0, HRQ}, 32'd1);
    exp_q.push_back(2'd2);
    serve("t4", 1'b1);
    maskReg = '0;

    // 5: HLDA withdrawn during a ch2 grant -> abort, pointer unchanged.
    do_reset();
    priorityType = 1'b1;
    DREQ = 4'b0100;
    exp_q.push_back(2'd2);
    wait_hrq("t5");
    HLDA = 1'b1;
    tick();
    score_grant("t5");
    HLDA = 1'b0;
    DREQ = 4'b1111;
    tick();
    check("t5_ab_dack", {28'd0, DACK}, 32'd0);
    check("t5_ab_hrq", {31'd0, HRQ}, 32'd0);
    check("t5_ab_gv", {31'd0, grantValid}, 32'd0);
    check("t5_ab_pulse", {31'd0, abortPulse}, 32'd1);
    check("t5_ab_last", {30'd0, dbg_last_granted}, 32'd3);
    tick();
    check("t5_pulse_end", {31'd0, abortPulse}, 32'd0);
    exp_q.push_back(2'd0);
    serve("t5_next", 1'b1);

    // 6: asynchronous reset in the middle of a grant.
    do_reset();
    DREQ = 4'b1000;
    exp_q.push_back(2'd3);
    wait_hrq("t6");
    HLDA = 1'b1;
    tick();
    score_grant("t6");
    #2 RESET_N = 1'b0;
    #1;
    check("t6_async_hrq", {31'd0, HRQ}, 32'd0);
    check("t6_async_dack", {28'd0, DACK}, 32'd0);
    check("t6_async_gv", {31'd0, grantValid}, 32'd0);
    @(negedge CLK);
    HLDA = 1'b0;
    DREQ = 4'b1111;
    priorityType = 1'b1;
    RESET_N = 1'b1;
    check("t6_state", {30'd0, dbg_state}, 32'd0);
    check("t6_last", {30'd0, dbg_last_granted}, 32'd3);
    exp_q.push_back(2'd0);
    serve("t6_next", 1'b1);

    check("sb_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
